// File: rtl/video_capture_pkg.sv
// Shared types, register map and pixel-to-palette conversion for video_capture.
// Build option VIDEO_CAPTURE_GREY_EN selects a luma-style grey index instead of RGB332.
package video_capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_HSTART = 3'd2;
  localparam logic [2:0] REG_HSTOP  = 3'd3;
  localparam logic [2:0] REG_VSTART = 3'd4;
  localparam logic [2:0] REG_VSTOP  = 3'd5;
  localparam logic [2:0] REG_BASE   = 3'd6;
  localparam logic [2:0] REG_STRIDE = 3'd7;

  function automatic logic [7:0] pix_to_index(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
`ifdef VIDEO_CAPTURE_GREY_EN
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
`else
    return {r[7:5], g[7:5], b[7:6]};
`endif
  endfunction

endpackage

// File: rtl/video_capture_if.sv
// Pixel input, register access and framebuffer write port of video_capture.
// master = stimulus/system side, slave = the capture block.
interface video_capture_if #(parameter int AW = 16);
  logic          vid_valid;
  logic [7:0]    vid_red;
  logic [7:0]    vid_green;
  logic [7:0]    vid_blue;
  logic          vid_hsyn;
  logic          vid_vsyn;
  logic          cfg_en;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_ready;

  modport master (
    output vid_valid, vid_red, vid_green, vid_blue, vid_hsyn, vid_vsyn,
    output cfg_en, cfg_we, cfg_addr, cfg_wdata, mem_ready,
    input  cfg_rdata, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  vid_valid, vid_red, vid_green, vid_blue, vid_hsyn, vid_vsyn,
    input  cfg_en, cfg_we, cfg_addr, cfg_wdata, mem_ready,
    output cfg_rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/video_capture_pack.sv
// Gathers 8 palette indices into a 64-bit word; reports a completed word combinationally
// when lane 7 is written or a non-empty partial word is flushed (unfilled lanes zero).
module video_capture_pack #(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pix_vld,
  input  logic [7:0]    pix_idx,
  input  logic [2:0]    lane,
  input  logic [AW-1:0] word_addr,
  input  logic          flush,
  input  logic          clear,
  output logic          done,
  output logic [63:0]   done_dat,
  output logic [AW-1:0] done_addr
);

  logic [63:0]   acc_q;
  logic [AW-1:0] addr_q;
  logic          has_q;
  logic [63:0]   merged;
  logic          last_lane;

  assign last_lane = pix_vld && (lane == 3'd7);

  always_comb begin
    merged = acc_q;
    merged[{lane, 3'b000} +: 8] = pix_idx;
    done      = 1'b0;
    done_dat  = acc_q;
    done_addr = addr_q;
    if (last_lane) begin
      done      = 1'b1;
      done_dat  = merged;
      done_addr = word_addr;
    end else if (flush && has_q) begin
      done = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      addr_q <= '0;
      has_q  <= 1'b0;
    end else if (clear || flush || last_lane) begin
      acc_q <= '0;
      has_q <= 1'b0;
    end else if (pix_vld) begin
      acc_q  <= merged;
      addr_q <= word_addr;
      has_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/video_capture.sv
// Captures a cropped RGB pixel stream as 8-bit palette indices, 8 per word, into framebuffer memory.
// Build option VIDEO_CAPTURE_GREY_EN switches the index conversion (see video_capture_pkg).
module video_capture
  import video_capture_pkg::*;
#(
  parameter int AW = 16,
  parameter int CW = 12
) (
  input  logic           clk_i,
  input  logic           rst_i,
  video_capture_if.slave bus
);

  state_t        state;
  logic          ctrl_arm, ctrl_cont, ovf;
  logic [7:0]    frames;
  logic [CW-1:0] hstart, hstop, vstart, vstop;
  logic [CW-1:0] sh_hstart, sh_hstop, sh_vstart, sh_vstop;
  logic [AW-1:0] base, stride, sh_stride, linebase;
  logic [CW-1:0] pix, line, rel;
  logic          vsyn_q, hsyn_q;

  logic          vsyn_rise, line_end, cfg_wr, ctrl_wr, disarm, in_h, in_v, cap;
  logic [AW-1:0] waddr;
  logic [31:0]   rd_mux;
  logic          pk_done;
  logic [63:0]   pk_dat;
  logic [AW-1:0] pk_addr;

  // A frame start masks a coincident line end.
  assign vsyn_rise = bus.vid_vsyn & ~vsyn_q;
  assign line_end  = bus.vid_hsyn & ~hsyn_q & ~vsyn_rise;
  assign cfg_wr    = bus.cfg_en & bus.cfg_we;
  assign ctrl_wr   = cfg_wr && (bus.cfg_addr == REG_CTRL);
  assign disarm    = ctrl_wr && !bus.cfg_wdata[0];
  assign in_h      = (pix >= sh_hstart) && (pix < sh_hstop);
  assign in_v      = (line >= sh_vstart) && (line < sh_vstop);
  assign cap       = bus.vid_valid && (state == CAPTURE) && !vsyn_rise && !line_end
                     && !disarm && in_h && in_v;
  assign rel       = pix - sh_hstart;
  assign waddr     = linebase + AW'(rel >> 3);

  video_capture_pack #(.AW(AW)) u_pack (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pix_vld   (cap),
    .pix_idx   (pix_to_index(bus.vid_red, bus.vid_green, bus.vid_blue)),
    .lane      (rel[2:0]),
    .word_addr (waddr),
    .flush     (line_end),
    .clear     (vsyn_rise | disarm),
    .done      (pk_done),
    .done_dat  (pk_dat),
    .done_addr (pk_addr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      frames <= '0;
    end else if (ctrl_wr) begin
      if (!bus.cfg_wdata[0])                       state <= IDLE;
      else if (state == IDLE || state == DONE)     state <= WAIT_SOF;
    end else if (vsyn_rise) begin
      case (state)
        WAIT_SOF: state <= CAPTURE;
        CAPTURE: begin
          frames <= frames + 8'd1;
          state  <= ctrl_cont ? CAPTURE : DONE;
        end
        default: state <= state;
      endcase
    end
  end

  // Position tracking; window/base/stride shadows are loaded at each frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsyn_q    <= 1'b0;
      hsyn_q    <= 1'b0;
      pix       <= '0;
      line      <= '0;
      linebase  <= '0;
      sh_hstart <= '0;
      sh_hstop  <= CW'(1024);
      sh_vstart <= '0;
      sh_vstop  <= CW'(768);
      sh_stride <= AW'(128);
    end else begin
      vsyn_q <= bus.vid_vsyn;
      hsyn_q <= bus.vid_hsyn;
      if (vsyn_rise) begin
        pix       <= '0;
        line      <= '0;
        linebase  <= base;
        sh_hstart <= hstart;
        sh_hstop  <= hstop;
        sh_vstart <= vstart;
        sh_vstop  <= vstop;
        sh_stride <= stride;
      end else if (line_end) begin
        pix  <= '0;
        line <= line + CW'(1);
        if (in_v) linebase <= linebase + sh_stride;
      end else if (bus.vid_valid && (pix != '1)) begin
        pix <= pix + CW'(1);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.cfg_addr)
      REG_CTRL:   rd_mux = {30'd0, ctrl_cont, ctrl_arm};
      REG_STATUS: rd_mux = {16'd0, frames, 4'd0, ovf, (state == DONE), state};
      REG_HSTART: rd_mux = 32'(hstart);
      REG_HSTOP:  rd_mux = 32'(hstop);
      REG_VSTART: rd_mux = 32'(vstart);
      REG_VSTOP:  rd_mux = 32'(vstop);
      REG_BASE:   rd_mux = 32'(base);
      REG_STRIDE: rd_mux = 32'(stride);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_arm      <= 1'b0;
      ctrl_cont     <= 1'b0;
      hstart        <= '0;
      hstop         <= CW'(1024);
      vstart        <= '0;
      vstop         <= CW'(768);
      base          <= '0;
      stride        <= AW'(128);
      ovf           <= 1'b0;
      bus.cfg_rdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      if (cfg_wr) begin
        case (bus.cfg_addr)
          REG_CTRL:   {ctrl_cont, ctrl_arm} <= bus.cfg_wdata[1:0];
          REG_STATUS: if (bus.cfg_wdata[3]) ovf <= 1'b0;
          REG_HSTART: hstart <= bus.cfg_wdata[CW-1:0];
          REG_HSTOP:  hstop  <= bus.cfg_wdata[CW-1:0];
          REG_VSTART: vstart <= bus.cfg_wdata[CW-1:0];
          REG_VSTOP:  vstop  <= bus.cfg_wdata[CW-1:0];
          REG_BASE:   base   <= bus.cfg_wdata[AW-1:0];
          REG_STRIDE: stride <= bus.cfg_wdata[AW-1:0];
        endcase
      end
      if (bus.cfg_en && !bus.cfg_we) bus.cfg_rdata <= rd_mux;

      if (bus.mem_we && bus.mem_ready) bus.mem_we <= 1'b0;
      // A stalled port drops the newly completed word; the pending one stays put.
      if (pk_done) begin
        if (bus.mem_we && !bus.mem_ready) begin
          ovf <= 1'b1;
        end else begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= pk_addr;
          bus.mem_wdata <= pk_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_capture.sv
// Directed self-checking bench for video_capture.
module tb_video_capture;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  video_capture_if #(.AW(16)) bus ();
  video_capture #(.AW(16), .CW(12)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  logic [15:0] wr_addr[$];
  logic [63:0] wr_dat[$];

  always @(negedge clk_i)
    if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_dat.push_back(bus.mem_wdata);
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] idx_model(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
`ifdef VIDEO_CAPTURE_GREY_EN
    int s;
    s = (int'(r) + 2 * int'(g) + int'(b)) / 4;
    return s[7:0];
`else
    return {r[7:5], g[7:5], b[7:6]};
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.vid_valid = 0; bus.vid_red = 0; bus.vid_green = 0; bus.vid_blue = 0;
    bus.vid_hsyn = 0;  bus.vid_vsyn = 0;
    bus.cfg_en = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.mem_ready = 1;
    step(); step();
    rst_i = 1'b0;
    step();
    wr_addr.delete();
    wr_dat.delete();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    bus.cfg_en = 1; bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
    step();
    bus.cfg_en = 0; bus.cfg_we = 0;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    bus.cfg_en = 1; bus.cfg_we = 0; bus.cfg_addr = a;
    step();
    bus.cfg_en = 0;
    d = bus.cfg_rdata;
  endtask

  task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.vid_valid = 1; bus.vid_red = r; bus.vid_green = g; bus.vid_blue = b;
    step();
    bus.vid_valid = 0;
  endtask

  task automatic pixels(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < n; i++) pixel(r, g, b);
  endtask

  task automatic hsync();
    bus.vid_hsyn = 1; step();
    bus.vid_hsyn = 0; step();
  endtask

  task automatic vsync();
    bus.vid_vsyn = 1; step();
    bus.vid_vsyn = 0; step();
  endtask

  function automatic logic [23:0] t1_rgb(input int l, input int p);
    logic [7:0] r, g, b;
    r = p[7:0];
    g = 8'(l * 40);
    b = 8'(p >> 2);
    return {r, g, b};
  endfunction

  logic [31:0] rd;
  logic [63:0] exp_w;
  logic [7:0]  grey;
  logic [15:0] t5_addr[6] = '{16'h40, 16'h50, 16'h40, 16'h50, 16'h40, 16'h50};

  initial begin
    grey = idx_model(8'h80, 8'h80, 8'h80);

    // Reset state
    do_reset();
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", bus.cfg_rdata, 0);
    cfg_read(3'd1, rd); chk("rst_status", rd, 0);
    cfg_read(3'd5, rd); chk("rst_vstop", rd, 768);

    // 1: default window, four full lines then frame end
    cfg_write(3'd0, 1);
    cfg_read(3'd1, rd); chk("t1_wait_sof", rd, 1);
    vsync();
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 1024; p++) begin
        logic [23:0] c;
        c = t1_rgb(l, p);
        pixel(c[23:16], c[15:8], c[7:0]);
      end
      hsync();
    end
    vsync();
    chk("t1_count", wr_addr.size(), 512);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < wr_addr.size() && k < 512; k++) begin
        logic [63:0] e;
        for (int ln = 0; ln < 8; ln++) begin
          logic [23:0] c;
          c = t1_rgb(k / 128, (k % 128) * 8 + ln);
          e[ln*8 +: 8] = idx_model(c[23:16], c[15:8], c[7:0]);
        end
        if (wr_addr[k] !== 16'(k) || wr_dat[k] !== e) bad++;
      end
      chk("t1_bad_words", bad, 0);
    end
    cfg_read(3'd1, rd); chk("t1_status_done", rd, 32'h107);

    // 2: HSTART=4 HSTOP=12, one red line -> single full word at BASE
    do_reset();
    cfg_write(3'd2, 4); cfg_write(3'd3, 12); cfg_write(3'd6, 32'h100);
    cfg_write(3'd0, 1);
    vsync();
    pixels(16, 8'hFF, 8'h00, 8'h00);
    hsync();
    chk("t2_count", wr_addr.size(), 1);
    chk("t2_addr", wr_addr[0], 16'h100);
    chk("t2_data", wr_dat[0], {8{idx_model(8'hFF, 8'h00, 8'h00)}});

    // 3: three-pixel window, partial word flushed by hsyn
    do_reset();
    cfg_write(3'd2, 2); cfg_write(3'd3, 5); cfg_write(3'd6, 32'h20);
    cfg_write(3'd0, 1);
    vsync();
    pixels(2, 8'h80, 8'h80, 8'h80);
    pixel(8'hFF, 8'hFF, 8'hFF);
    pixel(8'h00, 8'hFF, 8'h00);
    pixel(8'h00, 8'h00, 8'hFF);
    pixels(3, 8'h80, 8'h80, 8'h80);
    chk("t3_no_early_write", bus.mem_we, 0);
    bus.vid_hsyn = 1; step();
    chk("t3_flush_we", bus.mem_we, 1);
    chk("t3_flush_addr", bus.mem_addr, 16'h20);
    exp_w = {40'd0, idx_model(8'h00, 8'h00, 8'hFF), idx_model(8'h00, 8'hFF, 8'h00),
             idx_model(8'hFF, 8'hFF, 8'hFF)};
    chk("t3_flush_data", bus.mem_wdata, exp_w);
    bus.vid_hsyn = 0; step();
    chk("t3_we_drops", bus.mem_we, 0);

    // 4: stalled port -> first word held, overflow sticky until cleared
    do_reset();
    cfg_write(3'd0, 1);
    vsync();
    bus.mem_ready = 0;
    pixels(8, 8'h80, 8'h80, 8'h80);
    chk("t4_first_we", bus.mem_we, 1);
    pixels(12, 8'h80, 8'h80, 8'h80);
    chk("t4_held_we", bus.mem_we, 1);
    chk("t4_held_addr", bus.mem_addr, 0);
    chk("t4_held_data", bus.mem_wdata, {8{grey}});
    cfg_read(3'd1, rd); chk("t4_ovf_set", rd[3], 1);
    cfg_write(3'd1, 8);
    cfg_read(3'd1, rd); chk("t4_ovf_clr", rd[3], 0);
    bus.mem_ready = 1; step(); step();
    chk("t4_count", wr_addr.size(), 1);
    chk("t4_acc_addr", wr_addr[0], 0);

    // 5: continuous mode, 3 frames with a 2-line window, then disarm mid-line
    do_reset();
    cfg_write(3'd3, 8); cfg_write(3'd5, 2);
    cfg_write(3'd6, 32'h40); cfg_write(3'd7, 32'h10);
    cfg_write(3'd0, 3);
    vsync();
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 3; l++) begin
        pixels(10, 8'h80, 8'h80, 8'h80);
        hsync();
      end
      vsync();
    end
    chk("t5_count", wr_addr.size(), 6);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 6 && k < wr_addr.size(); k++)
        if (wr_addr[k] !== t5_addr[k] || wr_dat[k] !== {8{grey}}) bad++;
      chk("t5_bad_words", bad, 0);
    end
    cfg_read(3'd1, rd); chk("t5_status_cont", rd, 32'h302);
    pixels(4, 8'h80, 8'h80, 8'h80);
    cfg_write(3'd0, 0);
    pixels(8, 8'h80, 8'h80, 8'h80);
    hsync(); step(); step();
    chk("t5_no_more_writes", wr_addr.size(), 6);
    cfg_read(3'd1, rd); chk("t5_status_idle", rd, 32'h300);

    // 6: asynchronous reset with a word pending, then coincident vsyn+hsyn
    do_reset();
    cfg_write(3'd3, 500); cfg_write(3'd7, 7);
    cfg_write(3'd0, 1);
    vsync();
    pixels(8, 8'h80, 8'h80, 8'h80);
    chk("t6_we_pending", bus.mem_we, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_async_we", bus.mem_we, 0);
    chk("t6_async_wdata", bus.mem_wdata, 0);
    step();
    rst_i = 1'b0;
    step();
    wr_addr.delete(); wr_dat.delete();
    cfg_read(3'd3, rd); chk("t6_hstop_dflt", rd, 1024);
    cfg_read(3'd7, rd); chk("t6_stride_dflt", rd, 128);
    cfg_read(3'd0, rd); chk("t6_ctrl_dflt", rd, 0);
    cfg_read(3'd1, rd); chk("t6_status_dflt", rd, 0);
    cfg_write(3'd3, 8); cfg_write(3'd5, 1); cfg_write(3'd6, 32'h200);
    cfg_write(3'd0, 1);
    bus.vid_vsyn = 1; bus.vid_hsyn = 1; step();
    bus.vid_vsyn = 0; bus.vid_hsyn = 0; step();
    pixels(8, 8'h80, 8'h80, 8'h80);
    step(); step();
    chk("t6_vh_count", wr_addr.size(), 1);
    chk("t6_vh_addr", (wr_addr.size() > 0) ? wr_addr[0] : 16'hFFFF, 16'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
